// File: rtl/dcache_line_mem.sv
// -----------------------------------------------------------------------------
// dcache_line_mem
// Backing-memory line engine behind the dcache miss interface. A 0->1 edge on
// req starts either a plain line refill (wr=0) or a write-back of a dirty line
// followed by a refill (wr=1). Each phase waits LAT cycles before its beats.
// The refill can start at the critical word and wrap within the line (CWF=1).
//
// Ports
//   clk        : clock, all logic on the rising edge
//   reset_n    : synchronous active-low reset
//   req        : miss request, a new operation starts on its 0->1 edge
//   wr         : captured with the req edge; 1 = evict then refill
//   miss_addr  : byte address of the missing word (refill line + critical word)
//   evict_addr : byte address of the dirty line to write back
//   dirty_data : dirty line, word i = dirty_data[DW*i +: DW]
//   valid/data : refill beat strobe and data (registered)
//   wr_done    : one-cycle pulse when the write-back has completed
//   rd_done    : one-cycle pulse when the refill has completed
//   busy       : high from the accepted edge through the rd_done cycle
// -----------------------------------------------------------------------------
module dcache_line_mem #(
  parameter int AW     = 20,
  parameter int DW     = 32,
  parameter int NUM    = 4,
  parameter int MEM_AW = 10,
  parameter int LAT    = 2,
  parameter int CWF    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              wr,
  input  logic [AW-1:0]     miss_addr,
  input  logic [AW-1:0]     evict_addr,
  input  logic [NUM*DW-1:0] dirty_data,
  output logic              valid,
  output logic [DW-1:0]     data,
  output logic              wr_done,
  output logic              rd_done,
  output logic              busy
);

  localparam int LB = $clog2(NUM);              // word-in-line bits
  localparam int LW = MEM_AW - LB;              // line index bits
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WLAT  = 3'd1,
    WRITE = 3'd2,
    RLAT  = 3'd3,
    READ  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t             state_r;
  logic               req_q_r;
  logic [CW-1:0]      lat_cnt_r;
  logic [LB-1:0]      beat_r;
  logic               wr_r;
  logic [LW-1:0]      miss_line_r;
  logic [LW-1:0]      evict_line_r;
  logic [LB-1:0]      cw_r;
  logic [NUM*DW-1:0]  dirty_r;

  logic [DW-1:0]      mem_r [0:(2**MEM_AW)-1];

  logic               mem_we_s;
  logic [MEM_AW-1:0]  mem_waddr_s;
  logic [DW-1:0]      mem_wdata_s;
  logic [LB-1:0]      rd_off_s;
  logic [LB-1:0]      rd_word_s;
  logic [MEM_AW-1:0]  rd_addr_s;

  // Address bits above the array and the byte offset are intentionally ignored (aliasing).
  logic unused_s;
  assign unused_s = ^{miss_addr[AW-1:MEM_AW+2], miss_addr[1:0],
                      evict_addr[AW-1:MEM_AW+2], evict_addr[LB+1:0], wr_r};

  // Write port control: WRITE beat i stores dirty word i into evict line word i.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = '0;
    if (reset_n && (state_r == WRITE)) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = {evict_line_r, beat_r};
      mem_wdata_s = dirty_r[DW*int'(beat_r) +: DW];
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Read address: offset 0 is fetched on the last RLAT cycle, offset k+1 during READ beat k.
  // The LB-bit add wraps inside the line.
  always_comb begin
    rd_off_s = '0;
    if (state_r == READ) begin
      rd_off_s = beat_r + LB'(1'b1);
    end else begin
      rd_off_s = '0;
    end
    rd_word_s = cw_r + rd_off_s;
    rd_addr_s = {miss_line_r, rd_word_s};
  end

  // Line storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Operation sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      req_q_r      <= 1'b0;
      lat_cnt_r    <= '0;
      beat_r       <= '0;
      wr_r         <= 1'b0;
      miss_line_r  <= '0;
      evict_line_r <= '0;
      cw_r         <= '0;
      dirty_r      <= '0;
      valid        <= 1'b0;
      data         <= '0;
      wr_done      <= 1'b0;
      rd_done      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      req_q_r <= req;
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req && !req_q_r) begin
            wr_r         <= wr;
            miss_line_r  <= miss_addr[MEM_AW+1:LB+2];
            evict_line_r <= evict_addr[MEM_AW+1:LB+2];
            cw_r         <= (CWF != 0) ? miss_addr[LB+1:2] : '0;
            dirty_r      <= dirty_data;
            lat_cnt_r    <= CW'(LAT-1);
            busy         <= 1'b1;
            state_r      <= wr ? WLAT : RLAT;
          end
        end
        WLAT: begin
          if (lat_cnt_r == '0) begin
            beat_r  <= '0;
            state_r <= WRITE;
          end else begin
            lat_cnt_r <= lat_cnt_r - CW'(1'b1);
          end
        end
        WRITE: begin
          if (beat_r == LB'(NUM-1)) begin
            // wr_done lands in the first RLAT cycle
            lat_cnt_r <= CW'(LAT-1);
            wr_done   <= 1'b1;
            state_r   <= RLAT;
          end else begin
            beat_r <= beat_r + LB'(1'b1);
          end
        end
        RLAT: begin
          if (lat_cnt_r == '0) begin
            valid   <= 1'b1;
            data    <= mem_r[rd_addr_s];
            beat_r  <= '0;
            state_r <= READ;
          end else begin
            lat_cnt_r <= lat_cnt_r - CW'(1'b1);
          end
        end
        READ: begin
          if (beat_r == LB'(NUM-1)) begin
            valid   <= 1'b0;
            rd_done <= 1'b1;
            state_r <= DONE;
          end else begin
            data   <= mem_r[rd_addr_s];
            beat_r <= beat_r + LB'(1'b1);
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          valid   <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_line_mem.sv
// -----------------------------------------------------------------------------
// tb_dcache_line_mem
// Directed plus randomized checks of dcache_line_mem against a word-array
// reference model; per-cycle timing expectations come from the op type.
// -----------------------------------------------------------------------------
module tb_dcache_line_mem;

  localparam int AW = 20, DW = 32, NUM = 4, MEM_AW = 10, LAT = 2, CWF = 1;
  localparam int LB = 2;
  localparam int NLINES = (2**MEM_AW) / NUM;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req;
  logic              wr;
  logic [AW-1:0]     miss_addr;
  logic [AW-1:0]     evict_addr;
  logic [NUM*DW-1:0] dirty_data;
  logic              valid;
  logic [DW-1:0]     data;
  logic              wr_done;
  logic              rd_done;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [0:(2**MEM_AW)-1];
  int            wlines [$];

  always #5 clk = ~clk;

  dcache_line_mem #(.AW(AW), .DW(DW), .NUM(NUM), .MEM_AW(MEM_AW), .LAT(LAT), .CWF(CWF)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .miss_addr(miss_addr),
    .evict_addr(evict_addr), .dirty_data(dirty_data), .valid(valid), .data(data),
    .wr_done(wr_done), .rd_done(rd_done), .busy(busy)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [AW-1:0] a);
    return (int'(a) / (4 * NUM)) % NLINES;
  endfunction

  function automatic int word_of(input logic [AW-1:0] a);
    return (int'(a) / 4) % NUM;
  endfunction

  function automatic logic [AW-1:0] mk_addr(input int line, input int word);
    logic [AW-1:0] a;
    a = AW'($urandom);
    return (a & ~AW'(32'h00FFC)) | AW'(line * 16) | AW'(word * 4);
  endfunction

  function automatic logic [NUM*DW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // mode 0: req dropped in cycle 1; mode 1: req held high; mode 2: drop, then re-raise during READ.
  // abort_at > 0: apply reset in that cycle and check the abort.
  task automatic run_op(input logic w, input logic [AW-1:0] ma, input logic [AW-1:0] ea,
                        input logic [NUM*DW-1:0] dd, input int mode, input int tail,
                        input int abort_at);
    logic [DW-1:0] exp_q [$];
    int vs, rd_c, wd_c, cw;
    if (w) begin
      for (int i = 0; i < NUM; i++) model_mem[line_of(ea) * NUM + i] = dd[DW*i +: DW];
    end
    cw = (CWF != 0) ? word_of(ma) : 0;
    for (int k = 0; k < NUM; k++) exp_q.push_back(model_mem[line_of(ma) * NUM + (cw + k) % NUM]);
    vs   = (w ? LAT + NUM : 0) + LAT + 1;
    rd_c = vs + NUM;
    wd_c = w ? LAT + NUM + 1 : -1;

    @(negedge clk);
    wr = w; miss_addr = ma; evict_addr = ea; dirty_data = dd; req = 1'b1;
    for (int c = 1; c <= rd_c + tail; c++) begin
      @(negedge clk);
      chk($sformatf("c%0d busy", c), 64'(busy), 64'(c <= rd_c));
      chk($sformatf("c%0d valid", c), 64'(valid), 64'(c >= vs && c < vs + NUM));
      chk($sformatf("c%0d wr_done", c), 64'(wr_done), 64'(c == wd_c));
      chk($sformatf("c%0d rd_done", c), 64'(rd_done), 64'(c == rd_c));
      if (c >= vs && c < vs + NUM) chk($sformatf("c%0d data", c), 64'(data), 64'(exp_q[c - vs]));
      if (c == 1 && mode != 1) req = 1'b0;
      if (mode == 2 && c == vs + 1) req = 1'b1;
      if (c == abort_at) begin
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort valid", 64'(valid), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort rd_done", 64'(rd_done), 64'd0);
        reset_n = 1'b1;
        for (int j = 0; j < rd_c; j++) begin
          @(negedge clk);
          chk("post-abort rd_done", 64'(rd_done), 64'd0);
          chk("post-abort busy", 64'(busy), 64'd0);
        end
        return;
      end
    end
  endtask

  initial begin
    logic [NUM*DW-1:0] ln;
    int el, ml;
    logic w;
    for (int i = 0; i < 2**MEM_AW; i++) model_mem[i] = 'x;

    // Reset held three cycles with req high.
    reset_n = 1'b0; req = 1'b1; wr = 1'b0; miss_addr = '0; evict_addr = '0; dirty_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst valid", 64'(valid), 64'd0);
      chk("rst data", 64'(data), 64'd0);
      chk("rst wr_done", 64'(wr_done), 64'd0);
      chk("rst rd_done", 64'(rd_done), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
    end
    reset_n = 1'b1; req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle busy", 64'(busy), 64'd0);
    end

    // Preload line 0x00100 with A0..A3 and read it back from word 0.
    ln = rnd_line();
    run_op(1'b1, 20'h00100, 20'h00100, ln, 0, 1, 0);
    wlines.push_back(line_of(20'h00100));
    // Critical-word-first refill: expect A2,A3,A0,A1.
    run_op(1'b0, 20'h00108, 20'h00000, '0, 0, 1, 0);
    // Evict to 0x00200 then refill 0x00100; later refill of 0x00200.
    run_op(1'b1, 20'h00100, 20'h00200, rnd_line(), 0, 1, 0);
    wlines.push_back(line_of(20'h00200));
    run_op(1'b0, 20'h00200, 20'h00000, '0, 0, 1, 0);
    // Same-line evict/refill, from word 0 and from a wrapped critical word.
    run_op(1'b1, 20'h00300, 20'h00300, rnd_line(), 0, 1, 0);
    run_op(1'b1, 20'h0030C, 20'h00300, rnd_line(), 0, 1, 0);
    wlines.push_back(line_of(20'h00300));
    // Upper address bits alias onto the same array line.
    run_op(1'b0, 20'h40108, 20'h00000, '0, 0, 1, 0);

    // Edge during READ ignored, req held high after rd_done.
    run_op(1'b0, 20'h00104, 20'h00000, '0, 2, 3, 0);
    @(negedge clk);
    req = 1'b0;
    // One-cycle drop re-arms; then earliest restart straight after DONE.
    run_op(1'b0, 20'h0010C, 20'h00000, '0, 0, 0, 0);
    run_op(1'b0, 20'h00204, 20'h00000, '0, 0, 1, 0);

    // Reset after two refill beats, then a normal op.
    run_op(1'b0, 20'h00100, 20'h00000, '0, 0, 0, LAT + 2);
    run_op(1'b0, 20'h00304, 20'h00000, '0, 0, 1, 0);

    // Randomized ops over written lines.
    for (int n = 0; n < 16; n++) begin
      w  = 1'($urandom_range(0, 1));
      el = $urandom_range(0, NLINES - 1);
      if (w) wlines.push_back(el);
      ml = wlines[$urandom_range(0, wlines.size() - 1)];
      run_op(w, mk_addr(ml, $urandom_range(0, NUM - 1)), mk_addr(el, $urandom_range(0, NUM - 1)),
             rnd_line(), $urandom_range(0, 1) == 0 ? 0 : 2, $urandom_range(0, 1), 0);
      @(negedge clk);
      req = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
